// File: rtl/io_device_port.sv
// Device-side end of the INPR/FGI and OUTR/FGO handshake: a keyboard input FIFO
// that feeds INPR, and an output path that models printer busy time before the byte is offered.
module io_device_port #(
    parameter int DATA_W    = 8,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DELAY = 3
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [DATA_W-1:0] i_kbd_data,
    input  logic              i_kbd_valid,
    output logic              o_kbd_ready,
    output logic [DATA_W-1:0] o_inpr_data,
    output logic              o_fgi,
    input  logic              i_fgi_clr,
    input  logic [DATA_W-1:0] i_outr_data,
    output logic              o_fgo,
    input  logic              i_fgo_clr,
    output logic [DATA_W-1:0] o_prn_data,
    output logic              o_prn_valid,
    input  logic              i_prn_ready,
    input  logic              i_irq_en,
    output logic              o_int_req,
    output logic              o_overrun
);

    localparam int PTR_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int BSY_W = $clog2(OUT_DELAY + 1);

    typedef enum logic {
        IN_IDLE = 1'b0,
        IN_FULL = 1'b1
    } in_state_t;

    typedef enum logic [1:0] {
        OUT_READY = 2'd0,
        OUT_WAIT  = 2'd1,
        OUT_SEND  = 2'd2
    } out_state_t;

    logic [DATA_W-1:0] r_mem [IN_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    in_state_t         r_in_state;
    out_state_t        r_out_state;
    logic [BSY_W-1:0]  r_busy_cnt;
    logic [DATA_W-1:0] r_inpr_data;
    logic              r_fgi;
    logic              r_fgo;
    logic [DATA_W-1:0] r_prn_data;
    logic              r_prn_valid;
    logic              r_overrun;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [CNT_W-1:0]  w_count_next;
    in_state_t         w_in_next;
    logic              w_fgi_next;
    logic [DATA_W-1:0] w_inpr_next;
    out_state_t        w_out_next;
    logic [BSY_W-1:0]  w_busy_next;
    logic              w_fgo_next;
    logic              w_pv_next;
    logic [DATA_W-1:0] w_pd_next;
    logic              w_ovr_next;

    assign w_full   = (r_count == CNT_W'(IN_DEPTH));
    assign w_empty  = (r_count == {CNT_W{1'b0}});
    // A full FIFO refuses the byte; the keyboard holds it until space frees up.
    assign w_push   = i_kbd_valid & ~w_full;

    assign o_kbd_ready = ~w_full;
    assign o_inpr_data = r_inpr_data;
    assign o_fgi       = r_fgi;
    assign o_fgo       = r_fgo;
    assign o_prn_data  = r_prn_data;
    assign o_prn_valid = r_prn_valid;
    assign o_overrun   = r_overrun;
    assign o_int_req   = i_irq_en & (r_fgi | r_fgo);

    // FIFO occupancy update for push, pop, or both together.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Input FSM: move the FIFO head into INPR whenever the CPU has consumed the last byte.
    always_comb begin
        w_in_next   = r_in_state;
        w_pop       = 1'b0;
        w_fgi_next  = r_fgi;
        w_inpr_next = r_inpr_data;
        case (r_in_state)
            IN_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_inpr_next = r_mem[r_rd_ptr];
                    w_fgi_next  = 1'b1;
                    w_in_next   = IN_FULL;
                end else begin
                    w_in_next   = IN_IDLE;
                end
            end
            IN_FULL: begin
                if (i_fgi_clr) begin
                    w_fgi_next = 1'b0;
                    w_in_next  = IN_IDLE;
                end else begin
                    w_in_next  = IN_FULL;
                end
            end
            default: begin
                w_fgi_next = 1'b0;
                w_in_next  = IN_IDLE;
            end
        endcase
    end

    // Output FSM: capture OUTR, count down device busy time, then offer the byte to the printer.
    always_comb begin
        w_out_next  = r_out_state;
        w_busy_next = r_busy_cnt;
        w_fgo_next  = r_fgo;
        w_pv_next   = r_prn_valid;
        w_pd_next   = r_prn_data;
        // A write while the device is busy is flagged but never disturbs the byte in flight.
        w_ovr_next  = r_overrun | (i_fgo_clr & ~r_fgo);
        case (r_out_state)
            OUT_READY: begin
                if (i_fgo_clr) begin
                    w_pd_next   = i_outr_data;
                    w_fgo_next  = 1'b0;
                    w_busy_next = BSY_W'(OUT_DELAY);
                    w_out_next  = OUT_WAIT;
                end else begin
                    w_out_next  = OUT_READY;
                end
            end
            OUT_WAIT: begin
                if (r_busy_cnt == BSY_W'(1)) begin
                    w_pv_next   = 1'b1;
                    w_out_next  = OUT_SEND;
                end else begin
                    w_busy_next = r_busy_cnt - BSY_W'(1);
                    w_out_next  = OUT_WAIT;
                end
            end
            OUT_SEND: begin
                if (i_prn_ready) begin
                    w_pv_next  = 1'b0;
                    w_fgo_next = 1'b1;
                    w_out_next = OUT_READY;
                end else begin
                    w_out_next = OUT_SEND;
                end
            end
            default: begin
                w_pv_next  = 1'b0;
                w_fgo_next = 1'b1;
                w_out_next = OUT_READY;
            end
        endcase
    end

    // FIFO storage carries no control meaning, so it is written without reset.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_kbd_data;
        end
    end

    // Control state, pointers and flags; reset overrides every event in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr    <= {PTR_W{1'b0}};
            r_rd_ptr    <= {PTR_W{1'b0}};
            r_count     <= {CNT_W{1'b0}};
            r_in_state  <= IN_IDLE;
            r_out_state <= OUT_READY;
            r_busy_cnt  <= {BSY_W{1'b0}};
            r_inpr_data <= {DATA_W{1'b0}};
            r_fgi       <= 1'b0;
            r_fgo       <= 1'b1;
            r_prn_data  <= {DATA_W{1'b0}};
            r_prn_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count     <= w_count_next;
            r_in_state  <= w_in_next;
            r_out_state <= w_out_next;
            r_busy_cnt  <= w_busy_next;
            r_inpr_data <= w_inpr_next;
            r_fgi       <= w_fgi_next;
            r_fgo       <= w_fgo_next;
            r_prn_data  <= w_pd_next;
            r_prn_valid <= w_pv_next;
            r_overrun   <= w_ovr_next;
        end
    end

endmodule

// File: tb/tb_io_device_port.sv
// Table-driven bench for io_device_port: one vector per clock cycle, outputs checked
// just after the edge that consumed the vector's inputs, then a hand-written reset-mid-transfer sequence.
module tb_io_device_port;

    logic       clk;
    logic       reset;
    logic [7:0] kbd_data;
    logic       kbd_valid;
    logic       kbd_ready;
    logic [7:0] inpr_data;
    logic       fgi;
    logic       fgi_clr;
    logic [7:0] outr_data;
    logic       fgo;
    logic       fgo_clr;
    logic [7:0] prn_data;
    logic       prn_valid;
    logic       prn_ready;
    logic       irq_en;
    logic       int_req;
    logic       overrun;

    int n_checks = 0;
    int n_err    = 0;

    io_device_port #(.DATA_W(8), .IN_DEPTH(4), .OUT_DELAY(3)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_kbd_data  (kbd_data),
        .i_kbd_valid (kbd_valid),
        .o_kbd_ready (kbd_ready),
        .o_inpr_data (inpr_data),
        .o_fgi       (fgi),
        .i_fgi_clr   (fgi_clr),
        .i_outr_data (outr_data),
        .o_fgo       (fgo),
        .i_fgo_clr   (fgo_clr),
        .o_prn_data  (prn_data),
        .o_prn_valid (prn_valid),
        .i_prn_ready (prn_ready),
        .i_irq_en    (irq_en),
        .o_int_req   (int_req),
        .o_overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       kv;
        logic [7:0] kd;
        logic       ic;
        logic       oc;
        logic [7:0] od;
        logic       pr;
        logic       ie;
        logic       e_fgi;
        logic [7:0] e_inpr;
        logic       e_fgo;
        logic       e_pv;
        logic [7:0] e_pd;
        logic       e_kr;
        logic       e_ov;
        logic       e_irq;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic kv, input logic [7:0] kd, input logic ic,
                       input logic oc, input logic [7:0] od, input logic pr, input logic ie,
                       input logic e_fgi, input logic [7:0] e_inpr, input logic e_fgo,
                       input logic e_pv, input logic [7:0] e_pd, input logic e_kr,
                       input logic e_ov, input logic e_irq);
        vec_t v;
        v.rst = rst;   v.kv = kv;         v.kd = kd;       v.ic = ic;
        v.oc = oc;     v.od = od;         v.pr = pr;       v.ie = ie;
        v.e_fgi = e_fgi; v.e_inpr = e_inpr; v.e_fgo = e_fgo; v.e_pv = e_pv;
        v.e_pd = e_pd; v.e_kr = e_kr;     v.e_ov = e_ov;   v.e_irq = e_irq;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic kv, input logic [7:0] kd, input logic ic,
                         input logic oc, input logic [7:0] od, input logic pr, input logic ie);
        reset = rst; kbd_valid = kv; kbd_data = kd; fgi_clr = ic;
        fgo_clr = oc; outr_data = od; prn_ready = pr; irq_en = ie;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int waited;
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        //   rst  kv   kd     ic   oc   od     pr   ie  | fgi  inpr   fgo  pv   pd     kr   ov   irq
        add(1'b1,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b1, 1'b0,8'h00,1'b1,1'b0,8'h00,1'b1,1'b0,1'b1);
        add(1'b1,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b0,8'h00,1'b1,1'b0,8'h00,1'b1,1'b0,1'b0);
        // single keyboard byte, INP handshake, stray fgi_clr
        add(1'b0,1'b1,8'h41,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b0,8'h00,1'b1,1'b0,8'h00,1'b1,1'b0,1'b0);
        add(1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,8'h41,1'b1,1'b0,8'h00,1'b1,1'b0,1'b0);
        add(1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b1, 1'b1,8'h41,1'b1,1'b0,8'h00,1'b1,1'b0,1'b1);
        add(1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,8'h41,1'b1,1'b0,8'h00,1'b1,1'b0,1'b0);
        add(1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,8'h41,1'b1,1'b0,8'h00,1'b1,1'b0,1'b0);
        add(1'b0,1'b0,8'h00,1'b1,1'b0,8'h00,1'b0,1'b0, 1'b0,8'h41,1'b1,1'b0,8'h00,1'b1,1'b0,1'b0);
        add(1'b0,1'b0,8'h00,1'b1,1'b0,8'h00,1'b0,1'b1, 1'b0,8'h41,1'b1,1'b0,8'h00,1'b1,1'b0,1'b1);
        // five bytes back to back fill INPR plus four FIFO entries
        add(1'b0,1'b1,8'h01,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b0,8'h41,1'b1,1'b0,8'h00,1'b1,1'b0,1'b0);
        add(1'b0,1'b1,8'h02,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,8'h01,1'b1,1'b0,8'h00,1'b1,1'b0,1'b0);
        add(1'b0,1'b1,8'h03,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,8'h01,1'b1,1'b0,8'h00,1'b1,1'b0,1'b0);
        add(1'b0,1'b1,8'h04,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,8'h01,1'b1,1'b0,8'h00,1'b1,1'b0,1'b0);
        add(1'b0,1'b1,8'h05,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,8'h01,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0);
        add(1'b0,1'b1,8'h06,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,8'h01,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0);
        add(1'b0,1'b0,8'h00,1'b1,1'b0,8'h00,1'b0,1'b0, 1'b0,8'h01,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0);
        add(1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,8'h02,1'b1,1'b0,8'h00,1'b1,1'b0,1'b0);
        add(1'b0,1'b0,8'h00,1'b1,1'b0,8'h00,1'b0,1'b0, 1'b0,8'h02,1'b1,1'b0,8'h00,1'b1,1'b0,1'b0);
        add(1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,8'h03,1'b1,1'b0,8'h00,1'b1,1'b0,1'b0);
        add(1'b0,1'b0,8'h00,1'b1,1'b0,8'h00,1'b0,1'b0, 1'b0,8'h03,1'b1,1'b0,8'h00,1'b1,1'b0,1'b0);
        add(1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,8'h04,1'b1,1'b0,8'h00,1'b1,1'b0,1'b0);
        add(1'b0,1'b0,8'h00,1'b1,1'b0,8'h00,1'b0,1'b0, 1'b0,8'h04,1'b1,1'b0,8'h00,1'b1,1'b0,1'b0);
        add(1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,8'h05,1'b1,1'b0,8'h00,1'b1,1'b0,1'b0);
        add(1'b0,1'b0,8'h00,1'b1,1'b0,8'h00,1'b0,1'b0, 1'b0,8'h05,1'b1,1'b0,8'h00,1'b1,1'b0,1'b0);
        add(1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b1, 1'b0,8'h05,1'b1,1'b0,8'h00,1'b1,1'b0,1'b1);
        // OUT of 0x5A, overrun with 0xFF during busy time, printer stalls two cycles
        add(1'b0,1'b0,8'h00,1'b0,1'b1,8'h5A,1'b0,1'b1, 1'b0,8'h05,1'b0,1'b0,8'h5A,1'b1,1'b0,1'b0);
        add(1'b0,1'b0,8'h00,1'b0,1'b1,8'hFF,1'b0,1'b0, 1'b0,8'h05,1'b0,1'b0,8'h5A,1'b1,1'b1,1'b0);
        add(1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b0,8'h05,1'b0,1'b0,8'h5A,1'b1,1'b1,1'b0);
        add(1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b0,8'h05,1'b0,1'b1,8'h5A,1'b1,1'b1,1'b0);
        add(1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b0,8'h05,1'b0,1'b1,8'h5A,1'b1,1'b1,1'b0);
        add(1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b1, 1'b0,8'h05,1'b0,1'b1,8'h5A,1'b1,1'b1,1'b0);
        add(1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b1,1'b0, 1'b0,8'h05,1'b1,1'b0,8'h5A,1'b1,1'b1,1'b0);
        add(1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b1, 1'b0,8'h05,1'b1,1'b0,8'h5A,1'b1,1'b1,1'b1);
        // simultaneous INP and OUT; prn_ready held high through busy time is ignored
        add(1'b0,1'b1,8'h77,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b0,8'h05,1'b1,1'b0,8'h5A,1'b1,1'b1,1'b0);
        add(1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,8'h77,1'b1,1'b0,8'h5A,1'b1,1'b1,1'b0);
        add(1'b0,1'b0,8'h00,1'b1,1'b1,8'h33,1'b0,1'b0, 1'b0,8'h77,1'b0,1'b0,8'h33,1'b1,1'b1,1'b0);
        add(1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b1,1'b0, 1'b0,8'h77,1'b0,1'b0,8'h33,1'b1,1'b1,1'b0);
        add(1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b1,1'b0, 1'b0,8'h77,1'b0,1'b0,8'h33,1'b1,1'b1,1'b0);
        add(1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b1,1'b0, 1'b0,8'h77,1'b0,1'b1,8'h33,1'b1,1'b1,1'b0);
        add(1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b1,1'b0, 1'b0,8'h77,1'b1,1'b0,8'h33,1'b1,1'b1,1'b0);
        add(1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b1, 1'b0,8'h77,1'b1,1'b0,8'h33,1'b1,1'b1,1'b1);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i].rst, vq[i].kv, vq[i].kd, vq[i].ic, vq[i].oc, vq[i].od, vq[i].pr, vq[i].ie);
            @(posedge clk);
            #1;
            chk("fgi",       i, {7'd0, fgi},       {7'd0, vq[i].e_fgi});
            chk("inpr_data", i, inpr_data,         vq[i].e_inpr);
            chk("fgo",       i, {7'd0, fgo},       {7'd0, vq[i].e_fgo});
            chk("prn_valid", i, {7'd0, prn_valid}, {7'd0, vq[i].e_pv});
            chk("prn_data",  i, prn_data,          vq[i].e_pd);
            chk("kbd_ready", i, {7'd0, kbd_ready}, {7'd0, vq[i].e_kr});
            chk("overrun",   i, {7'd0, overrun},   {7'd0, vq[i].e_ov});
            chk("int_req",   i, {7'd0, int_req},   {7'd0, vq[i].e_irq});
        end

        // Reset while the printer byte is pending and two keyboard bytes sit in the FIFO.
        @(negedge clk); drive(1'b0, 1'b1, 8'hAA, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0);
        @(negedge clk); drive(1'b0, 1'b1, 8'hBB, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk); drive(1'b0, 1'b1, 8'hCC, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk); drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        waited = 0;
        while (prn_valid !== 1'b1 && waited < 10) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk("t6_send_reached", waited, {7'd0, prn_valid}, 8'h01);
        chk("t6_send_data",    waited, prn_data,          8'hC3);
        chk("t6_inpr_before",  waited, inpr_data,         8'hAA);

        @(negedge clk); drive(1'b1, 1'b1, 8'hEE, 1'b1, 1'b1, 8'h99, 1'b1, 1'b1);
        @(posedge clk); #1;
        chk("t6_rst_fgi",       0, {7'd0, fgi},       8'h00);
        chk("t6_rst_fgo",       0, {7'd0, fgo},       8'h01);
        chk("t6_rst_prn_valid", 0, {7'd0, prn_valid}, 8'h00);
        chk("t6_rst_prn_data",  0, prn_data,          8'h00);
        chk("t6_rst_inpr",      0, inpr_data,         8'h00);
        chk("t6_rst_overrun",   0, {7'd0, overrun},   8'h00);
        chk("t6_rst_kbd_ready", 0, {7'd0, kbd_ready}, 8'h01);
        chk("t6_rst_int_req",   0, {7'd0, int_req},   8'h01);

        for (int k = 1; k <= 3; k++) begin
            @(negedge clk); drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            @(posedge clk); #1;
            chk("t6_post_prn_valid", k, {7'd0, prn_valid}, 8'h00);
            chk("t6_post_fgi",       k, {7'd0, fgi},       8'h00);
            chk("t6_post_fgo",       k, {7'd0, fgo},       8'h01);
            chk("t6_post_inpr",      k, inpr_data,         8'h00);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
